// File: rtl/instr_dispatcher_pkg.sv
// ----------------------------------------------------------------------------
// instr_dispatcher_pkg
// Shared definitions for the instruction dispatcher: opcode values, the bit
// positions of the instruction fields, the mem_op command encodings, the FSM
// state encoding and small helpers that map opcodes onto memory commands.
// ----------------------------------------------------------------------------
package instr_dispatcher_pkg;

    // Opcode values carried in instr_in[63:60]
    localparam logic [3:0] OP_NOP     = 4'h0;
    localparam logic [3:0] OP_LOAD_W  = 4'h1;
    localparam logic [3:0] OP_LOAD_A  = 4'h2;
    localparam logic [3:0] OP_COMPUTE = 4'h3;
    localparam logic [3:0] OP_STORE   = 4'h4;
    localparam logic [3:0] OP_SYNC    = 4'h5;
    localparam logic [3:0] OP_HALT    = 4'hF;

    // Instruction field bit positions
    localparam int OPC_HI  = 63;
    localparam int OPC_LO  = 60;
    localparam int ADDR_HI = 59;
    localparam int ADDR_LO = 44;
    localparam int LEN_HI  = 43;
    localparam int LEN_LO  = 28;

    // mem_op command encodings
    localparam logic [2:0] MEMOP_NONE    = 3'd0;
    localparam logic [2:0] MEMOP_LOAD_W  = 3'd1;
    localparam logic [2:0] MEMOP_LOAD_A  = 3'd2;
    localparam logic [2:0] MEMOP_COMPUTE = 3'd3;
    localparam logic [2:0] MEMOP_STORE   = 3'd4;

    // Dispatcher FSM states
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_DECODE    = 3'd1,
        ST_ISSUE     = 3'd2,
        ST_WAIT_IDLE = 3'd3,
        ST_HALTED    = 3'd4
    } state_e;

    // Memory command issued for an opcode; MEMOP_NONE for non-transfer opcodes
    function automatic logic [2:0] opcode_to_memop(input logic [3:0] op);
        logic [2:0] m;
        case (op)
            OP_LOAD_W:  m = MEMOP_LOAD_W;
            OP_LOAD_A:  m = MEMOP_LOAD_A;
            OP_COMPUTE: m = MEMOP_COMPUTE;
            OP_STORE:   m = MEMOP_STORE;
            default:    m = MEMOP_NONE;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/instr_field_decode.sv
// ----------------------------------------------------------------------------
// instr_field_decode
// Combinational split of a 64-bit instruction word into opcode, address and
// length fields, plus a flag for opcodes outside the defined set.
// Ports:
//   i_instr   - raw instruction word
//   o_opcode  - bits [63:60]
//   o_addr    - bits [59:44]
//   o_len     - bits [43:28]
//   o_illegal - opcode is not NOP/LOAD_W/LOAD_A/COMPUTE/STORE/SYNC/HALT
// ----------------------------------------------------------------------------
module instr_field_decode
    import instr_dispatcher_pkg::*;
(
    input  logic [63:0] i_instr,
    output logic [3:0]  o_opcode,
    output logic [15:0] o_addr,
    output logic [15:0] o_len,
    output logic        o_illegal
);

    // Low bits carry no meaning for the dispatcher
    logic w_unused_bits;
    assign w_unused_bits = ^i_instr[LEN_LO-1:0];

    assign o_opcode = i_instr[OPC_HI:OPC_LO];
    assign o_addr   = i_instr[ADDR_HI:ADDR_LO];
    assign o_len    = i_instr[LEN_HI:LEN_LO];

    // Flag any opcode outside the defined set
    always_comb begin
        o_illegal = 1'b0;
        case (o_opcode)
            OP_NOP, OP_LOAD_W, OP_LOAD_A, OP_COMPUTE,
            OP_STORE, OP_SYNC, OP_HALT: o_illegal = 1'b0;
            default:                    o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_dispatcher.sv
// ----------------------------------------------------------------------------
// instr_dispatcher
// Accepts instructions one at a time, decodes them and either issues a burst
// of per-beat memory commands, waits for the systolic array to drain, halts,
// or simply retires the instruction.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   instr_in/valid    - instruction from the buffer; instr_ready = accept
//   mem_op/addr/valid - per-beat command to the array side; mem_ready accepts
//   array_idle        - array has no work in flight (used by SYNC)
//   busy, halted      - FSM status
//   illegal_op        - sticky undefined-opcode flag
//   retired           - wrapping count of retired legal instructions
// ----------------------------------------------------------------------------
module instr_dispatcher
    import instr_dispatcher_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [63:0]       instr_in,
    input  logic              instr_valid,
    output logic              instr_ready,
    output logic [2:0]        mem_op,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_valid,
    input  logic              mem_ready,
    input  logic              array_idle,
    output logic              busy,
    output logic              halted,
    output logic              illegal_op,
    output logic [15:0]       retired
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0]  LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0]  LEN_ZERO = {LEN_W{1'b0}};

    logic [3:0]  w_opcode;
    logic [15:0] w_addr;
    logic [15:0] w_len;
    logic        w_illegal;
    logic        w_accept;

    state_e            r_state;
    logic [3:0]        r_opcode;
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_len;
    logic              r_illegal;
    logic [LEN_W-1:0]  r_cnt;
    logic              r_instr_ready;
    logic [2:0]        r_mem_op;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_valid;
    logic              r_busy;
    logic              r_halted;
    logic              r_illegal_op;
    logic [15:0]       r_retired;

    instr_field_decode u_decode (
        .i_instr   (instr_in),
        .o_opcode  (w_opcode),
        .o_addr    (w_addr),
        .o_len     (w_len),
        .o_illegal (w_illegal)
    );

    assign w_accept = instr_valid && r_instr_ready;

    // Dispatcher FSM with all status and command outputs registered
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_opcode      <= OP_NOP;
            r_addr        <= '0;
            r_len         <= '0;
            r_illegal     <= 1'b0;
            r_cnt         <= '0;
            r_instr_ready <= 1'b1;
            r_mem_op      <= MEMOP_NONE;
            r_mem_addr    <= '0;
            r_mem_valid   <= 1'b0;
            r_busy        <= 1'b0;
            r_halted      <= 1'b0;
            r_illegal_op  <= 1'b0;
            r_retired     <= 16'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_opcode      <= w_opcode;
                        r_addr        <= ADDR_W'(w_addr);
                        r_len         <= LEN_W'(w_len);
                        r_illegal     <= w_illegal;
                        r_instr_ready <= 1'b0;
                        r_busy        <= 1'b1;
                        r_state       <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (r_illegal) begin
                        // Dropped without retiring
                        r_illegal_op  <= 1'b1;
                        r_instr_ready <= 1'b1;
                        r_busy        <= 1'b0;
                        r_state       <= ST_IDLE;
                    end else if (r_opcode == OP_HALT) begin
                        r_halted  <= 1'b1;
                        r_busy    <= 1'b0;
                        r_retired <= r_retired + 16'd1;
                        r_state   <= ST_HALTED;
                    end else if (r_opcode == OP_SYNC) begin
                        r_state <= ST_WAIT_IDLE;
                    end else if ((opcode_to_memop(r_opcode) != MEMOP_NONE) && (r_len != LEN_ZERO)) begin
                        r_mem_valid <= 1'b1;
                        r_mem_op    <= opcode_to_memop(r_opcode);
                        r_mem_addr  <= r_addr;
                        r_cnt       <= r_len;
                        r_state     <= ST_ISSUE;
                    end else begin
                        // NOP or zero-length transfer retires immediately
                        r_retired     <= r_retired + 16'd1;
                        r_instr_ready <= 1'b1;
                        r_busy        <= 1'b0;
                        r_state       <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    if (mem_ready) begin
                        r_mem_addr <= r_mem_addr + ADDR_ONE;
                        r_cnt      <= r_cnt - LEN_ONE;
                        if (r_cnt == LEN_ONE) begin
                            r_mem_valid   <= 1'b0;
                            r_mem_op      <= MEMOP_NONE;
                            r_retired     <= r_retired + 16'd1;
                            r_instr_ready <= 1'b1;
                            r_busy        <= 1'b0;
                            r_state       <= ST_IDLE;
                        end
                    end
                end
                ST_WAIT_IDLE: begin
                    if (array_idle) begin
                        r_retired     <= r_retired + 16'd1;
                        r_instr_ready <= 1'b1;
                        r_busy        <= 1'b0;
                        r_state       <= ST_IDLE;
                    end
                end
                ST_HALTED: begin
                    r_halted      <= 1'b1;
                    r_instr_ready <= 1'b0;
                end
                default: begin
                    r_state       <= ST_IDLE;
                    r_mem_valid   <= 1'b0;
                    r_mem_op      <= MEMOP_NONE;
                    r_instr_ready <= 1'b1;
                    r_busy        <= 1'b0;
                end
            endcase
        end
    end

    assign instr_ready = r_instr_ready;
    assign mem_op      = r_mem_op;
    assign mem_addr    = r_mem_addr;
    assign mem_valid   = r_mem_valid;
    assign busy        = r_busy;
    assign halted      = r_halted;
    assign illegal_op  = r_illegal_op;
    assign retired     = r_retired;

endmodule

// File: tb/tb_instr_dispatcher.sv
// ----------------------------------------------------------------------------
// tb_instr_dispatcher
// Directed scenarios for instr_dispatcher. Expected memory beats are queued
// when an instruction is issued; a negedge monitor compares every presented
// beat against the queue head and pops it on handshake. Status outputs are
// checked inline by the stimulus process.
// ----------------------------------------------------------------------------
module tb_instr_dispatcher;

    logic        clk;
    logic        rst;
    logic [63:0] instr_in;
    logic        instr_valid;
    logic        instr_ready;
    logic [2:0]  mem_op;
    logic [15:0] mem_addr;
    logic        mem_valid;
    logic        mem_ready;
    logic        array_idle;
    logic        busy;
    logic        halted;
    logic        illegal_op;
    logic [15:0] retired;

    typedef struct packed {
        logic [2:0]  op;
        logic [15:0] addr;
    } beat_t;

    beat_t exp_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    instr_dispatcher #(.ADDR_W(16), .LEN_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_in    (instr_in),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .mem_op      (mem_op),
        .mem_addr    (mem_addr),
        .mem_valid   (mem_valid),
        .mem_ready   (mem_ready),
        .array_idle  (array_idle),
        .busy        (busy),
        .halted      (halted),
        .illegal_op  (illegal_op),
        .retired     (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] mk(input logic [3:0] op, input logic [15:0] a, input logic [15:0] l);
        return {op, a, l, 28'h0000000};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for instr_ready, then presents the instruction for one cycle
    task automatic send(input logic [63:0] w);
        int k;
        k = 0;
        while (!instr_ready && k < 50) begin
            tick();
            k++;
        end
        if (!instr_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: instr_ready still 0 after %0d cycles", k);
        end
        instr_in    = w;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
    endtask

    task automatic push_beats(input logic [2:0] op, input logic [15:0] a, input int n);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.op   = op;
            b.addr = a + 16'(i);
            exp_q.push_back(b);
        end
    endtask

    // Beat monitor: every presented beat must match the queue head
    always @(negedge clk) begin
        if (mem_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_beat: op %0d addr 0x%0h with nothing expected", mem_op, mem_addr);
            end else begin
                check("beat_op", 32'(mem_op), 32'(exp_q[0].op));
                check("beat_addr", 32'(mem_addr), 32'(exp_q[0].addr));
                if (mem_ready === 1'b1) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        rst         = 1'b1;
        instr_in    = 64'd0;
        instr_valid = 1'b0;
        mem_ready   = 1'b1;
        array_idle  = 1'b1;
        tick();
        tick();
        check("rst_instr_ready", 32'(instr_ready), 32'd1);
        check("rst_mem_valid",   32'(mem_valid),   32'd0);
        check("rst_mem_op",      32'(mem_op),      32'd0);
        check("rst_mem_addr",    32'(mem_addr),    32'd0);
        check("rst_busy",        32'(busy),        32'd0);
        check("rst_halted",      32'(halted),      32'd0);
        check("rst_illegal",     32'(illegal_op),  32'd0);
        check("rst_retired",     32'(retired),     32'd0);
        rst = 1'b0;
        tick();

        // LOAD_W 0x0010 len 4, mem_ready high: four consecutive beats
        push_beats(3'd1, 16'h0010, 4);
        send(mk(4'h1, 16'h0010, 16'd4));
        check("lw_decode_busy",  32'(busy),      32'd1);
        check("lw_decode_valid", 32'(mem_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("lw_beat_valid", 32'(mem_valid), 32'd1);
        end
        tick();
        check("lw_end_valid",   32'(mem_valid),   32'd0);
        check("lw_end_ready",   32'(instr_ready), 32'd1);
        check("lw_end_op",      32'(mem_op),      32'd0);
        check("lw_end_busy",    32'(busy),        32'd0);
        check("lw_retired",     32'(retired),     32'd1);

        // STORE 0xFFFE len 3, beat 2 stalled two cycles, address wraps
        push_beats(3'd4, 16'hFFFE, 3);
        send(mk(4'h4, 16'hFFFE, 16'd3));
        tick();
        tick();
        mem_ready = 1'b0;
        tick();
        check("st_stall_addr", 32'(mem_addr), 32'h0000FFFF);
        tick();
        mem_ready = 1'b1;
        check("st_stall_addr2", 32'(mem_addr), 32'h0000FFFF);
        tick();
        check("st_beat3_addr", 32'(mem_addr), 32'h00000000);
        tick();
        check("st_end_valid", 32'(mem_valid), 32'd0);
        check("st_retired",   32'(retired),   32'd2);

        // SYNC with array_idle low for five cycles
        array_idle = 1'b0;
        send(mk(4'h5, 16'h0000, 16'd0));
        tick();
        for (int i = 0; i < 5; i++) begin
            check("sync_wait_ready", 32'(instr_ready), 32'd0);
            check("sync_wait_busy",  32'(busy),        32'd1);
            tick();
        end
        array_idle = 1'b1;
        check("sync_rise_ready", 32'(instr_ready), 32'd0);
        tick();
        check("sync_done_ready", 32'(instr_ready), 32'd1);
        check("sync_retired",    32'(retired),     32'd3);

        // Illegal opcode 0x7 then NOP
        send(mk(4'h7, 16'h1234, 16'd2));
        tick();
        check("ill_flag",    32'(illegal_op),  32'd1);
        check("ill_retired", 32'(retired),     32'd3);
        check("ill_ready",   32'(instr_ready), 32'd1);
        send(mk(4'h0, 16'h0000, 16'd0));
        tick();
        check("nop_retired", 32'(retired),    32'd4);
        check("ill_sticky",  32'(illegal_op), 32'd1);

        // HALT then a LOAD_A that must never be accepted
        send(mk(4'hF, 16'h0000, 16'd0));
        tick();
        check("halt_flag",    32'(halted),      32'd1);
        check("halt_retired", 32'(retired),     32'd5);
        check("halt_busy",    32'(busy),        32'd0);
        instr_in    = mk(4'h2, 16'h0200, 16'd2);
        instr_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("halt_ready", 32'(instr_ready), 32'd0);
            tick();
        end
        check("halt_hold", 32'(halted), 32'd1);
        instr_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("halt_rst_halted",  32'(halted),      32'd0);
        check("halt_rst_retired", 32'(retired),     32'd0);
        check("halt_rst_illegal", 32'(illegal_op),  32'd0);
        check("halt_rst_ready",   32'(instr_ready), 32'd1);
        tick();

        // Reset during beat 2 of a len-8 LOAD_A
        push_beats(3'd2, 16'h0100, 2);
        send(mk(4'h2, 16'h0100, 16'd8));
        tick();
        tick();
        check("mid_beat2_addr", 32'(mem_addr), 32'h00000101);
        rst = 1'b1;
        tick();
        check("mid_rst_valid",   32'(mem_valid),   32'd0);
        check("mid_rst_retired", 32'(retired),     32'd0);
        check("mid_rst_ready",   32'(instr_ready), 32'd1);
        // Instruction presented while rst is high is discarded
        instr_in    = mk(4'h1, 16'h0300, 16'd2);
        instr_valid = 1'b1;
        tick();
        rst         = 1'b0;
        instr_valid = 1'b0;
        check("rst_accept_busy", 32'(busy), 32'd0);
        tick();
        tick();
        check("rst_accept_valid", 32'(mem_valid), 32'd0);
        check("rst_accept_ready", 32'(instr_ready), 32'd1);
        tick();

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
